// File: rtl/seq_alu_pkg.sv
// Shared definitions for seq_alu: ALUOP encodings, FSM state encoding and the
// op-class helper that marks the multi-cycle operations.
package seq_alu_pkg;

    localparam logic [2:0] ALU_FWD = 3'b000;
    localparam logic [2:0] ALU_ADD = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SUB = 3'b100;
    localparam logic [2:0] ALU_MUL = 3'b101;
    localparam logic [2:0] ALU_SLL = 3'b110;
    localparam logic [2:0] ALU_SRA = 3'b111;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Bit i set means ALUOP i may take more than one edge.
    localparam logic [7:0] MULTI_CYCLE_OPS = 8'b1110_0000;

    function automatic logic is_multi_cycle(input logic [2:0] op);
        return MULTI_CYCLE_OPS[op];
    endfunction

endpackage

// File: rtl/seq_alu_mul.sv
// Shift-add multiplier datapath for seq_alu: one partial-product step per
// enabled edge; the *_next outputs show the product after the current step.
module seq_alu_mul #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] mcand_in,
    input  logic [WIDTH-1:0] mplr_in,
    output logic [WIDTH-1:0] prod_hi_next,
    output logic [WIDTH-1:0] prod_lo_next
);

    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] mplr_q, mplr_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH:0]   sum_s;

    // Accumulator and multiplier shift right together; the low product bits
    // migrate into the vacated multiplier bits.
    always_comb begin
        sum_s        = {1'b0, acc_q} + (mplr_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
        prod_hi_next = sum_s[WIDTH:1];
        prod_lo_next = {sum_s[0], mplr_q[WIDTH-1:1]};
        acc_d        = acc_q;
        mplr_d       = mplr_q;
        mcand_d      = mcand_q;
        if (load) begin
            acc_d   = {WIDTH{1'b0}};
            mplr_d  = mplr_in;
            mcand_d = mcand_in;
        end else if (step) begin
            acc_d  = prod_hi_next;
            mplr_d = prod_lo_next;
        end else begin
            acc_d = acc_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q   <= {WIDTH{1'b0}};
            mplr_q  <= {WIDTH{1'b0}};
            mcand_q <= {WIDTH{1'b0}};
        end else begin
            acc_q   <= acc_d;
            mplr_q  <= mplr_d;
            mcand_q <= mcand_d;
        end
    end

endmodule

// File: rtl/seq_alu.sv
// Registered ALU with START/BUSY/DONE handshake; MUL and non-zero shifts are
// iterative. Define SEQ_ALU_FLAGS_EN to add ZERO/NEGATIVE/CARRY/OVERFLOW.
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             START,
    input  logic [2:0]       ALUOP,
    input  logic [WIDTH-1:0] OPERAND1,
    input  logic [WIDTH-1:0] OPERAND2,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] RESULT,
    output logic [WIDTH-1:0] RESULT_HI
`ifdef SEQ_ALU_FLAGS_EN
    ,
    output logic             ZERO,
    output logic             NEGATIVE,
    output logic             CARRY,
    output logic             OVERFLOW
`endif
);

    localparam int SHW = $clog2(WIDTH);
    localparam logic [SHW:0] CNT_MUL = (SHW+1)'(WIDTH);
    localparam logic [SHW:0] CNT_ONE = (SHW+1)'(1);

    state_t           state_q, state_d;
    logic [SHW:0]     cnt_q, cnt_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] result_hi_q, result_hi_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;

    logic [SHW-1:0]   shamt_s;
    logic             accept_s, multi_start_s, last_step_s;
    logic [WIDTH-1:0] mul_hi_s, mul_lo_s;

    assign shamt_s       = OPERAND2[SHW-1:0];
    assign accept_s      = (state_q == ST_IDLE) && START;
    assign multi_start_s = accept_s && is_multi_cycle(ALUOP) &&
                           ((ALUOP == ALU_MUL) || (shamt_s != {SHW{1'b0}}));
    assign last_step_s   = (cnt_q == CNT_ONE);

    seq_alu_mul #(.WIDTH(WIDTH)) u_mul (
        .clk          (CLK),
        .rst          (RESET),
        .load         (multi_start_s && (ALUOP == ALU_MUL)),
        .step         ((state_q == ST_RUN) && (op_q == ALU_MUL)),
        .mcand_in     (OPERAND1),
        .mplr_in      (OPERAND2),
        .prod_hi_next (mul_hi_s),
        .prod_lo_next (mul_lo_s)
    );

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q     <= ST_IDLE;
            cnt_q       <= {(SHW+1){1'b0}};
            op_q        <= ALU_FWD;
            shreg_q     <= {WIDTH{1'b0}};
            result_q    <= {WIDTH{1'b0}};
            result_hi_q <= {WIDTH{1'b0}};
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            shreg_q     <= shreg_d;
            result_q    <= result_d;
            result_hi_q <= result_hi_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (multi_start_s) state_d = ST_RUN; else state_d = ST_IDLE;
            ST_RUN:  if (last_step_s)   state_d = ST_IDLE; else state_d = ST_RUN;
            default: state_d = ST_IDLE;
        endcase
    end

    // Operation latch, iterative shift register and result write-back.
    always_comb begin
        cnt_d       = cnt_q;
        op_d        = op_q;
        shreg_d     = shreg_q;
        result_d    = result_q;
        result_hi_d = result_hi_q;
        done_d      = 1'b0;
        if (accept_s) begin
            op_d = ALUOP;
            if (multi_start_s) begin
                cnt_d   = (ALUOP == ALU_MUL) ? CNT_MUL : {1'b0, shamt_s};
                shreg_d = OPERAND1;
            end else begin
                done_d      = 1'b1;
                result_hi_d = {WIDTH{1'b0}};
                case (ALUOP)
                    ALU_FWD: result_d = OPERAND2;
                    ALU_ADD: result_d = OPERAND1 + OPERAND2;
                    ALU_AND: result_d = OPERAND1 & OPERAND2;
                    ALU_OR:  result_d = OPERAND1 | OPERAND2;
                    ALU_SUB: result_d = OPERAND1 - OPERAND2;
                    default: result_d = OPERAND1;
                endcase
            end
        end else if (state_q == ST_RUN) begin
            cnt_d   = cnt_q - CNT_ONE;
            shreg_d = (op_q == ALU_SRA) ? {shreg_q[WIDTH-1], shreg_q[WIDTH-1:1]}
                                        : {shreg_q[WIDTH-2:0], 1'b0};
            if (last_step_s) begin
                done_d      = 1'b1;
                result_d    = (op_q == ALU_MUL) ? mul_lo_s : shreg_d;
                result_hi_d = (op_q == ALU_MUL) ? mul_hi_s : {WIDTH{1'b0}};
            end else begin
                done_d = 1'b0;
            end
        end else begin
            done_d = 1'b0;
        end
        busy_d = (state_d == ST_RUN);
    end

    assign BUSY      = busy_q;
    assign DONE      = done_q;
    assign RESULT    = result_q;
    assign RESULT_HI = result_hi_q;

`ifdef SEQ_ALU_FLAGS_EN
    logic             zero_q, zero_d, neg_q, neg_d, carry_q, carry_d, ovf_q, ovf_d;
    logic [WIDTH:0]   add_full_s, sub_full_s;
    logic [2:0]       eff_op_s;

    // Flags follow the value written at DONE; single-cycle ops use live operands.
    always_comb begin
        add_full_s = {1'b0, OPERAND1} + {1'b0, OPERAND2};
        sub_full_s = {1'b0, OPERAND1} - {1'b0, OPERAND2};
        eff_op_s   = accept_s ? ALUOP : op_q;
        zero_d     = zero_q;
        neg_d      = neg_q;
        carry_d    = carry_q;
        ovf_d      = ovf_q;
        if (done_d) begin
            zero_d = (result_d == {WIDTH{1'b0}}) && (result_hi_d == {WIDTH{1'b0}});
            neg_d  = result_d[WIDTH-1];
            case (eff_op_s)
                ALU_ADD: begin
                    carry_d = add_full_s[WIDTH];
                    ovf_d   = (OPERAND1[WIDTH-1] == OPERAND2[WIDTH-1]) &&
                              (add_full_s[WIDTH-1] != OPERAND1[WIDTH-1]);
                end
                ALU_SUB: begin
                    carry_d = sub_full_s[WIDTH];
                    ovf_d   = (OPERAND1[WIDTH-1] != OPERAND2[WIDTH-1]) &&
                              (sub_full_s[WIDTH-1] != OPERAND1[WIDTH-1]);
                end
                ALU_MUL: begin
                    carry_d = (result_hi_d != {WIDTH{1'b0}});
                    ovf_d   = 1'b0;
                end
                default: begin
                    carry_d = 1'b0;
                    ovf_d   = 1'b0;
                end
            endcase
        end else begin
            zero_d = zero_q;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            zero_q  <= 1'b0;
            neg_q   <= 1'b0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            zero_q  <= zero_d;
            neg_q   <= neg_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
        end
    end

    assign ZERO     = zero_q;
    assign NEGATIVE = neg_q;
    assign CARRY    = carry_q;
    assign OVERFLOW = ovf_q;
`endif

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, registered successor to the 8-bit combinational ALU of the single-cycle datapath.
- Adds subtract, iterative multiply and iterative shifts, with a START/BUSY/DONE handshake, so the control unit can stall on multi-cycle operations.
- Sits between the register file read ports and the write-back mux.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 4..32.
- SHW, $clog2(WIDTH), shift-amount field width; derived, not overridden.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RESET  in  1  asynchronous, active-high reset.
- START  in  1  request; sampled only when BUSY=0.
- ALUOP  in  3  operation select.
- OPERAND1  in  WIDTH  first operand (shift source).
- OPERAND2  in  WIDTH  second operand (shift amount in [SHW-1:0]).
- BUSY  out  1  multi-cycle operation in progress.
- DONE  out  1  one-cycle pulse; RESULT/RESULT_HI valid.
- RESULT  out  WIDTH  result, low half for MUL.
- RESULT_HI  out  WIDTH  product high half for MUL; 0 for all other ops.

Behaviour:
- Reset values: BUSY=0, DONE=0, RESULT=0, RESULT_HI=0, FSM=IDLE, counter=0, flags=0. Reset mid-operation aborts it; no DONE.
- ALUOP encoding:
  - 000 FWD: OPERAND2.
  - 001 ADD.
  - 010 AND.
  - 011 OR.
  - 100 SUB: OPERAND1-OPERAND2.
  - 101 MUL: unsigned.
  - 110 SLL: OPERAND1 << OPERAND2[SHW-1:0].
  - 111 SRA: arithmetic right shift.
- Arithmetic is modulo 2^WIDTH. MUL is unsigned WIDTH×WIDTH → 2·WIDTH, split into RESULT_HI:RESULT.
- FSM states IDLE and RUN.
- IDLE, START=1, single-cycle op (FWD/ADD/AND/OR/SUB, or shift with amount 0):
  - At that edge RESULT is written and DONE<=1; FSM stays IDLE, BUSY stays 0.
  - Latency is 1 edge.
- IDLE, START=1, MUL:
  - Operands latched, counter<=WIDTH, BUSY<=1, goto RUN.
  - One shift-add step per edge.
  - On the step where counter==1: write result, DONE<=1, BUSY<=0, goto IDLE.
  - DONE is high in the cycle after edge t+WIDTH, where t is the START edge.
- IDLE, START=1, SLL/SRA with amount n>0:
  - Latch operand, counter<=n, BUSY<=1, goto RUN.
  - Shift one bit per edge; DONE after edge t+n.
  - SRA replicates the MSB.
- DONE is high for exactly one cycle; otherwise 0.
- RESULT and RESULT_HI hold their last value until the next DONE.
- START while BUSY=1: ignored, with no effect on the in-flight operation or latched operands.
- Back-to-back: START may be asserted in the cycle DONE is high, since BUSY is already 0 and the request is accepted.
- Operands and ALUOP are latched at acceptance; later input changes do not affect the in-flight result.
- START=0 in IDLE: no state change.

Optional Feature:
- SEQ_ALU_FLAGS_EN defined adds four output ports, each 1 bit: ZERO, NEGATIVE, CARRY, OVERFLOW.
  - Flags are registered with DONE and held until the next DONE.
  - ZERO: RESULT==0 (MUL: both halves 0).
  - NEGATIVE: RESULT[WIDTH-1].
  - CARRY: ADD carry-out; SUB borrow (1 when OPERAND1<OPERAND2 unsigned); MUL: RESULT_HI!=0; else 0.
  - OVERFLOW: signed overflow for ADD/SUB; else 0.
  - All flags reset to 0.
- Undefined: ports absent, no flag logic.

Decomposition:
- Package seq_alu_pkg holds:
  - ALUOP encodings (ALU_FWD..ALU_SRA) as 3-bit constants.
  - FSM state encodings ST_IDLE/ST_RUN.
  - Op-class helper constant marking the multi-cycle ops (MUL, SLL, SRA).
- Sub-module seq_alu_mul contains the WIDTH-cycle shift-add multiplier datapath (accumulator, multiplier shift register). The step enable comes from the seq_alu FSM.
- Shifts and single-cycle ops stay in the top level.

Test Plan (WIDTH=8):
- ADD/FWD/AND/OR:
  - ADD 0x07+0x3B → DONE one edge after START, RESULT=0x42, RESULT_HI=0, BUSY never 1.
  - FWD → RESULT=0x03; AND 0x51&0x73 → 0x51; OR 0x65|0x33 → 0x77.
- SUB 0x03-0x05 → RESULT=0xFE; with flags: NEGATIVE=1, CARRY=1, OVERFLOW=0, ZERO=0.
- MUL 0x0F×0x11 → BUSY high 8 cycles, DONE after edge t+8, RESULT=0xFF, RESULT_HI=0x00.
  - MUL 0xFF×0xFF → RESULT=0x01, RESULT_HI=0xFE, CARRY=1.
- SRA 0x90 by 3 → DONE after 3 edges, RESULT=0xF2. SLL 0x81 by 0 → single-cycle, RESULT=0x81.
- START with ADD issued during MUL BUSY → ignored; MUL result correct, exactly one DONE.
  - Then START in the DONE cycle → accepted, next DONE one edge later.
- RESET asserted asynchronously at cycle 4 of a MUL → BUSY, DONE, RESULT and flags 0 immediately; no DONE after release; next ADD correct.
